// File: rtl/sync_fifo_p_if.sv
// sync_fifo_p_if -- handshake/status bundle for sync_fifo_p.
//   master : producer/consumer side (drives clr, wen, wdata, ren)
//   slave  : FIFO side (drives rdata, rvalid, count and all flags)
// Parameters must match the FIFO instance they are bound to.
interface sync_fifo_p_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              clr;
  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              ovf;
  logic              udf;

  modport master (
    output clr, wen, wdata, ren,
    input  rdata, rvalid, count, full, empty, almost_full, almost_empty, ovf, udf
  );

  modport slave (
    input  clr, wen, wdata, ren,
    output rdata, rvalid, count, full, empty, almost_full, almost_empty, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_p.sv
// sync_fifo_p -- parametrised single-clock FIFO with registered read data.
//   clk   : single clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_p_if.slave (clr/wen/wdata/ren in; rdata/rvalid/count,
//           full/empty/almost_full/almost_empty, sticky ovf/udf out)
// DEPTH need not be a power of two; pointers wrap at DEPTH-1.
// Build option SYNC_FIFO_OVERWRITE_EN: a write while full (no read) replaces
// the oldest entry instead of being dropped. ovf sets in either build.
module sync_fifo_p #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_p_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              full_w, empty_w, wa, ra;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_w  = (cnt_q == CW'(DEPTH));
  assign empty_w = (cnt_q == '0);

  assign ra = bus.ren && !empty_w && !bus.clr;
`ifdef SYNC_FIFO_OVERWRITE_EN
  assign wa = bus.wen && !bus.clr;
`else
  assign wa = bus.wen && (!full_w || ra) && !bus.clr;
`endif

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (wa) wptr_d = ptr_inc(wptr_q);
      // A write accepted while full without a read (overwrite build only)
      // drops the oldest entry, so the read pointer follows.
      if (ra || (wa && full_w)) rptr_d = ptr_inc(rptr_q);
      if (ra) begin
        rdata_d  = mem_q[rptr_q];
        rvalid_d = 1'b1;
      end
      if (wa && !ra && !full_w)      cnt_d = cnt_q + 1'b1;
      else if (ra && !wa)            cnt_d = cnt_q - 1'b1;
      if (bus.wen && full_w && !ra)  ovf_d = 1'b1;
      if (bus.ren && empty_w)        udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wa) mem_q[wptr_q] <= bus.wdata;
  end

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.count        = cnt_q;
  assign bus.full         = full_w && rst_n;
  assign bus.empty        = empty_w && rst_n;
  assign bus.almost_full  = (cnt_q >= CW'(AFULL_TH)) && rst_n;
  assign bus.almost_empty = (cnt_q <= CW'(AEMPTY_TH)) && rst_n;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;
endmodule

// File: tb/tb_sync_fifo_p.sv
module tb_sync_fifo_p;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  sync_fifo_p_if #(.DATA_W(8), .DEPTH(16)) if16 ();
  sync_fifo_p_if #(.DATA_W(8), .DEPTH(5))  if5 ();
  sync_fifo_p_if #(.DATA_W(8), .DEPTH(4))  if4 ();

  sync_fifo_p #(.DATA_W(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2))
    u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  sync_fifo_p #(.DATA_W(8), .DEPTH(5))
    u5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  sync_fifo_p #(.DATA_W(8), .DEPTH(4))
    u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  // Reference model for the DEPTH=16 instance: a plain queue plus flags.
  logic [7:0] mq[$];
  bit         m_ovf, m_udf, m_rvalid;
  logic [7:0] m_rdata;
  logic [4:0] exp_cnt;

  task automatic m16_reset();
    mq.delete();
    m_ovf = 0; m_udf = 0; m_rvalid = 0; m_rdata = 8'h00;
  endtask

  task automatic m16_step(input bit c, input bit w, input bit r, input logic [7:0] d);
    int n;
    n = mq.size();
    m_rvalid = 0;
    if (c) begin
      mq.delete(); m_ovf = 0; m_udf = 0;
      return;
    end
    if (r && n == 0) m_udf = 1;
    if (w && !r && n == 16) begin
      m_ovf = 1;
`ifdef SYNC_FIFO_OVERWRITE_EN
      mq.delete(0);
      mq.push_back(d);
`endif
    end else begin
      if (r && n > 0) begin
        m_rdata = mq[0];
        mq.delete(0);
        m_rvalid = 1;
      end
      if (w) mq.push_back(d);
    end
  endtask

  task automatic cyc16(input bit c, input bit w, input bit r, input logic [7:0] d);
    if16.clr = c; if16.wen = w; if16.ren = r; if16.wdata = d;
    m16_step(c, w, r, d);
    @(posedge clk); #1;
    if16.clr = 0; if16.wen = 0; if16.ren = 0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (if16.count !== 5'd0) begin bad++; $display("FAIL rst_count: got %0d exp 0", if16.count); end
    total++; if (if16.empty !== 1'b0) begin bad++; $display("FAIL rst_empty: got %b exp 0", if16.empty); end
    total++; if (if16.full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b exp 0", if16.full); end
    total++; if (if16.almost_empty !== 1'b0) begin bad++; $display("FAIL rst_aempty: got %b exp 0", if16.almost_empty); end
    total++; if (if16.rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b exp 0", if16.rvalid); end
    @(negedge clk); rst_n = 1; m16_reset();
    @(posedge clk); #1;
    total++; if (if16.empty !== 1'b1) begin bad++; $display("FAIL rel_empty: got %b exp 1", if16.empty); end
    total++; if (if16.almost_empty !== 1'b1) begin bad++; $display("FAIL rel_aempty: got %b exp 1", if16.almost_empty); end
    for (int i = 0; i < 3; i++) cyc16(0, 1, 0, 8'(8'h30 + i));
    cyc16(0, 0, 1, 8'h00);
    total++; if (if16.rvalid !== 1'b1 || if16.rdata !== 8'h30) begin bad++; $display("FAIL pre_rst_read: got v=%b d=%h exp v=1 d=30", if16.rvalid, if16.rdata); end
    #2 rst_n = 0;
    #1;
    total++; if (if16.count !== 5'd0) begin bad++; $display("FAIL mid_rst_count: got %0d exp 0", if16.count); end
    total++; if (if16.empty !== 1'b0) begin bad++; $display("FAIL mid_rst_empty: got %b exp 0", if16.empty); end
    total++; if (if16.full !== 1'b0) begin bad++; $display("FAIL mid_rst_full: got %b exp 0", if16.full); end
    total++; if (if16.rvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_rvalid: got %b exp 0", if16.rvalid); end
    total++; if (if16.rdata !== 8'h00) begin bad++; $display("FAIL mid_rst_rdata: got %h exp 00", if16.rdata); end
    @(negedge clk); rst_n = 1; m16_reset();
    @(posedge clk); #1;
    total++; if (if16.empty !== 1'b1 || if16.count !== 5'd0) begin bad++; $display("FAIL post_rst: got empty=%b count=%0d exp empty=1 count=0", if16.empty, if16.count); end
  endtask

  task automatic test_fill_drain();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 1; i <= 5; i++) begin
        if5.wen = 1; if5.wdata = 8'(i);
        @(posedge clk); #1;
        total++; if (if5.count !== 3'(i)) begin bad++; $display("FAIL fd_count: rep %0d got %0d exp %0d", rep, if5.count, i); end
        total++; if (if5.full !== (i == 5)) begin bad++; $display("FAIL fd_full: rep %0d count %0d got %b", rep, i, if5.full); end
      end
      if5.wen = 0;
      for (int i = 1; i <= 5; i++) begin
        if5.ren = 1;
        @(posedge clk); #1;
        total++; if (if5.rvalid !== 1'b1 || if5.rdata !== 8'(i)) begin bad++; $display("FAIL fd_read: rep %0d got v=%b d=%h exp v=1 d=%h", rep, if5.rvalid, if5.rdata, 8'(i)); end
        total++; if (if5.count !== 3'(5 - i)) begin bad++; $display("FAIL fd_drain_count: got %0d exp %0d", if5.count, 5 - i); end
      end
      if5.ren = 0;
      total++; if (if5.empty !== 1'b1) begin bad++; $display("FAIL fd_empty: rep %0d got %b exp 1", rep, if5.empty); end
      @(posedge clk); #1;
      total++; if (if5.rvalid !== 1'b0) begin bad++; $display("FAIL fd_rvalid_pulse: got %b exp 0", if5.rvalid); end
    end
  endtask

  task automatic test_thresholds();
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) cyc16(0, 1, 0, 8'($urandom));
      total++; if (if16.almost_empty !== (n <= 2)) begin bad++; $display("FAIL th_aempty_up: count %0d got %b", n, if16.almost_empty); end
      total++; if (if16.almost_full !== (n >= 14)) begin bad++; $display("FAIL th_afull_up: count %0d got %b", n, if16.almost_full); end
    end
    total++; if (if16.full !== 1'b1) begin bad++; $display("FAIL th_full: got %b exp 1", if16.full); end
    for (int n = 15; n >= 0; n--) begin
      cyc16(0, 0, 1, 8'h00);
      total++; if (if16.rdata !== m_rdata) begin bad++; $display("FAIL th_rdata: got %h exp %h", if16.rdata, m_rdata); end
      total++; if (if16.almost_empty !== (n <= 2)) begin bad++; $display("FAIL th_aempty_dn: count %0d got %b", n, if16.almost_empty); end
      total++; if (if16.almost_full !== (n >= 14)) begin bad++; $display("FAIL th_afull_dn: count %0d got %b", n, if16.almost_full); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] head;
    for (int i = 0; i < 16; i++) cyc16(0, 1, 0, 8'($urandom));
    head = mq[0];
    cyc16(0, 1, 1, 8'hEE);
    total++; if (if16.count !== 5'd16) begin bad++; $display("FAIL sim_full_count: got %0d exp 16", if16.count); end
    total++; if (if16.rvalid !== 1'b1 || if16.rdata !== head) begin bad++; $display("FAIL sim_full_read: got v=%b d=%h exp v=1 d=%h", if16.rvalid, if16.rdata, head); end
    total++; if (if16.ovf !== 1'b0) begin bad++; $display("FAIL sim_full_ovf: got %b exp 0", if16.ovf); end
    for (int i = 0; i < 16; i++) cyc16(0, 0, 1, 8'h00);
    total++; if (if16.rdata !== 8'hEE) begin bad++; $display("FAIL sim_last_word: got %h exp ee", if16.rdata); end
    cyc16(0, 1, 1, 8'h77);
    total++; if (if16.count !== 5'd1) begin bad++; $display("FAIL sim_empty_count: got %0d exp 1", if16.count); end
    total++; if (if16.rvalid !== 1'b0) begin bad++; $display("FAIL sim_empty_rvalid: got %b exp 0", if16.rvalid); end
    total++; if (if16.udf !== 1'b1) begin bad++; $display("FAIL sim_empty_udf: got %b exp 1", if16.udf); end
    cyc16(0, 0, 1, 8'h00);
    total++; if (if16.rdata !== 8'h77 || if16.empty !== 1'b1) begin bad++; $display("FAIL sim_drain: got d=%h empty=%b exp d=77 empty=1", if16.rdata, if16.empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_rd [4];
`ifdef SYNC_FIFO_OVERWRITE_EN
    exp_rd = '{8'h0B, 8'h0C, 8'h0D, 8'h0E};
`else
    exp_rd = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
`endif
    for (int i = 0; i < 5; i++) begin
      if4.wen = 1; if4.wdata = 8'(8'h0A + i);
      @(posedge clk); #1;
    end
    if4.wen = 0;
    total++; if (if4.ovf !== 1'b1) begin bad++; $display("FAIL ov_ovf: got %b exp 1", if4.ovf); end
    total++; if (if4.count !== 3'd4 || if4.full !== 1'b1) begin bad++; $display("FAIL ov_count: got %0d full=%b exp 4 full=1", if4.count, if4.full); end
    for (int i = 0; i < 4; i++) begin
      if4.ren = 1;
      @(posedge clk); #1;
      total++; if (if4.rvalid !== 1'b1 || if4.rdata !== exp_rd[i]) begin bad++; $display("FAIL ov_read%0d: got v=%b d=%h exp v=1 d=%h", i, if4.rvalid, if4.rdata, exp_rd[i]); end
    end
    if4.ren = 0;
    total++; if (if4.empty !== 1'b1 || if4.ovf !== 1'b1) begin bad++; $display("FAIL ov_end: got empty=%b ovf=%b exp 1 1", if4.empty, if4.ovf); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 17; i++) cyc16(0, 1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 9; i++) cyc16(0, 0, 1, 8'h00);
    total++; if (if16.count !== 5'd7 || if16.ovf !== 1'b1) begin bad++; $display("FAIL fl_pre: got count=%0d ovf=%b exp 7 1", if16.count, if16.ovf); end
    cyc16(1, 1, 1, 8'h99);
    total++; if (if16.count !== 5'd0) begin bad++; $display("FAIL fl_count: got %0d exp 0", if16.count); end
    total++; if (if16.ovf !== 1'b0 || if16.udf !== 1'b0) begin bad++; $display("FAIL fl_sticky: got ovf=%b udf=%b exp 0 0", if16.ovf, if16.udf); end
    total++; if (if16.rvalid !== 1'b0 || if16.empty !== 1'b1) begin bad++; $display("FAIL fl_rvalid: got v=%b empty=%b exp 0 1", if16.rvalid, if16.empty); end
    cyc16(0, 1, 0, 8'h5A);
    cyc16(0, 0, 1, 8'h00);
    total++; if (if16.rvalid !== 1'b1 || if16.rdata !== 8'h5A || if16.count !== 5'd0) begin bad++; $display("FAIL fl_roundtrip: got v=%b d=%h c=%0d exp 1 5a 0", if16.rvalid, if16.rdata, if16.count); end
  endtask

  task automatic test_random();
    int wb, rb;
    bit c, w, r;
    cyc16(1, 0, 0, 8'h00);
    for (int k = 0; k < 600; k++) begin
      wb = ((k / 100) % 2 == 0) ? 75 : 25;
      rb = 100 - wb;
      c = ($urandom_range(0, 99) < 2);
      w = ($urandom_range(0, 99) < wb);
      r = ($urandom_range(0, 99) < rb);
      cyc16(c, w, r, 8'($urandom));
      exp_cnt = 5'(mq.size());
      total++; if (if16.count !== exp_cnt) begin bad++; $display("FAIL rnd_count: cyc %0d got %0d exp %0d", k, if16.count, exp_cnt); end
      total++; if (if16.full !== (mq.size() == 16) || if16.empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_fe: cyc %0d got full=%b empty=%b size %0d", k, if16.full, if16.empty, mq.size()); end
      total++; if (if16.almost_full !== (mq.size() >= 14) || if16.almost_empty !== (mq.size() <= 2)) begin bad++; $display("FAIL rnd_almost: cyc %0d got af=%b ae=%b size %0d", k, if16.almost_full, if16.almost_empty, mq.size()); end
      total++; if (if16.ovf !== m_ovf || if16.udf !== m_udf) begin bad++; $display("FAIL rnd_err: cyc %0d got ovf=%b udf=%b exp %b %b", k, if16.ovf, if16.udf, m_ovf, m_udf); end
      total++; if (if16.rvalid !== m_rvalid || if16.rdata !== m_rdata) begin bad++; $display("FAIL rnd_read: cyc %0d got v=%b d=%h exp v=%b d=%h", k, if16.rvalid, if16.rdata, m_rvalid, m_rdata); end
    end
  endtask

  initial begin
    if16.clr = 0; if16.wen = 0; if16.ren = 0; if16.wdata = 8'h00;
    if5.clr = 0;  if5.wen = 0;  if5.ren = 0;  if5.wdata = 8'h00;
    if4.clr = 0;  if4.wen = 0;  if4.ren = 0;  if4.wdata = 8'h00;
    m16_reset();
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_simultaneous();
    test_overflow();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_p.md
# sync_fifo_p

Parametrised single-clock FIFO, successor to the fixed 8-bit/16-entry FIFO. Adds configurable data width and depth, including non-power-of-two depths, and registered read data with a valid strobe. Also adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Sits between producer and consumer logic in the same clock domain. Overwrite-on-full is a compile-time option.

## Interface
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 16, number of entries (>=2, need not be a power of two)
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH
- Derived: AW = $clog2(DEPTH), CW = $clog2(DEPTH+1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush
- wen  in  1  write request
- wdata  in  DATA_W  write data
- ren  in  1  read request
- rdata  out  DATA_W  registered read data
- rvalid  out  1  rdata updated this cycle
- count  out  CW  current occupancy
- full, empty  out  1  count==DEPTH / count==0
- almost_full, almost_empty  out  1  threshold flags
- ovf, udf  out  1  sticky overflow / underflow

## Operation
- Storage: DEPTH x DATA_W array with no reset. Write and read pointers are AW bits wide. Each pointer wraps from DEPTH-1 to 0, not at 2^AW.
- Priority, highest first: reset, clr, then wen/ren.
- clr: pointers, count, rvalid, ovf and udf go to 0. wen/ren are ignored that cycle. Array contents are left as they are.
- Write accept: `wa = wen && (!full || ren_acc || OVERWRITE)`. An accepted write stores wdata at the write pointer and increments the write pointer.
- Read accept: `ra = ren && !empty`. An accepted read loads mem[rptr] into rdata, increments the read pointer and pulses rvalid.
- There is no write-to-read bypass. When empty with wen && ren, the write is accepted and the read is rejected.
- count: +1 on write only, -1 on read only, unchanged on both. count never exceeds DEPTH and never goes below 0.
- Full with wen && ren: both are accepted and count stays at DEPTH.
- Rejected read (ren && empty): pointers unchanged, rdata holds its value, rvalid=0, udf sets.
- Write while full without a simultaneous read:
  - ovf sets in all builds.
  - Storage behaviour depends on the Configuration macro.
- ovf and udf are cleared only by rst_n or clr.
- Flag definitions:
  - empty = (count==0) && rst_n
  - full = (count==DEPTH)
  - almost_full and almost_empty are combinational from count.
  - All flags are 0 while rst_n is low.

## Timing
- Reset (asynchronous, takes effect immediately):
  - pointers, count, rdata, rvalid, ovf and udf are 0
  - full, empty, almost_full and almost_empty are 0
- rdata/rvalid latency: 1 cycle after the edge that samples an accepted ren. rvalid is a single-cycle pulse per accepted read. Back-to-back reads give one word per cycle.
- Flag latency: count and all flags reflect a write or read on the edge after it is sampled.
- Throughput: a write is visible to the read side on the next cycle. A write sampled at edge N can be read by ren at edge N+1, with rdata valid after edge N+1.
- Reset mid-operation: in-flight rvalid is dropped, and data in the array becomes unreachable.

## Configuration
- Macro SYNC_FIFO_OVERWRITE_EN.
- Defined: a write while full without a read is accepted. It overwrites the oldest entry and advances both pointers. count stays at DEPTH and ovf sets.
- Undefined: a write while full without a read is dropped. Array and pointers are unchanged, count stays at DEPTH and ovf sets.

## Test plan
- Reset with DEPTH=16:
  - Stimulus: assert rst_n=0 mid-stream.
  - Response: immediately count=0, empty=0, full=0, rvalid=0. After release, empty=1.
- Fill/drain with DEPTH=5 (non-power-of-two), DATA_W=8:
  - Stimulus: write 0x01..0x05, then read 5.
  - Response: full=1 at count=5, rdata sequence 0x01..0x05 each 1 cycle after ren, empty=1 at end.
  - Repeat 3 times to exercise pointer wrap.
- Thresholds with DEPTH=16, AFULL_TH=14, AEMPTY_TH=2:
  - almost_empty=1 at count 0..2.
  - almost_full=1 at count 14..16.
- Simultaneous read/write:
  - At count=16, wen && ren: count stays 16, oldest word read, no ovf.
  - At count=0, wen && ren: count becomes 1, rvalid=0, udf=1.
- Overflow with DEPTH=4 holding 0xA..0xD, then write 0xE:
  - Without macro: ovf=1, reads return 0xA,0xB,0xC,0xD.
  - With SYNC_FIFO_OVERWRITE_EN: ovf=1, reads return 0xB,0xC,0xD,0xE.
- Flush:
  - Stimulus: at count=7 with ovf=1, assert clr together with wen and ren.
  - Response: next cycle count=0, ovf=0, rvalid=0, and the next write/read round-trips correctly.
